// File: rtl/bure_stage_id.sv
// RV32I instruction-decode stage: single-entry registered micro-op between fetch and execute.
// Owns the IF->ID handshake (valid/ready) and drops the held and incoming instruction on flush.
module bure_stage_id #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rstn,
  input  logic                   i_flush,
  input  logic                   i_instr_valid,
  input  logic [INSTR_WIDTH-1:0] i_instr,
  input  logic [ADDR_WIDTH-1:0]  i_pc,
  output logic                   o_instr_ready,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [ADDR_WIDTH-1:0]  o_pc,
  output logic [3:0]             o_op_class,
  output logic [2:0]             o_funct3,
  output logic                   o_funct7b5,
  output logic [4:0]             o_rs1_addr,
  output logic [4:0]             o_rs2_addr,
  output logic [4:0]             o_rd_addr,
  output logic                   o_rs1_used,
  output logic                   o_rs2_used,
  output logic                   o_rd_we,
  output logic [DATA_WIDTH-1:0]  o_imm,
  output logic                   o_illegal
);

  localparam logic [3:0] CLS_NONE   = 4'd0;
  localparam logic [3:0] CLS_OP     = 4'd1;
  localparam logic [3:0] CLS_OP_IMM = 4'd2;
  localparam logic [3:0] CLS_LOAD   = 4'd3;
  localparam logic [3:0] CLS_STORE  = 4'd4;
  localparam logic [3:0] CLS_BRANCH = 4'd5;
  localparam logic [3:0] CLS_JAL    = 4'd6;
  localparam logic [3:0] CLS_JALR   = 4'd7;
  localparam logic [3:0] CLS_LUI    = 4'd8;
  localparam logic [3:0] CLS_AUIPC  = 4'd9;
  localparam logic [3:0] CLS_FENCE  = 4'd10;
  localparam logic [3:0] CLS_SYSTEM = 4'd11;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Field extraction
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1_addr;
  logic [4:0] rs2_addr;
  logic [4:0] rd_addr;

  assign opcode   = i_instr[6:0];
  assign funct3   = i_instr[14:12];
  assign funct7   = i_instr[31:25];
  assign rs1_addr = i_instr[19:15];
  assign rs2_addr = i_instr[24:20];
  assign rd_addr  = i_instr[11:7];

  // Immediate formats, all sign-extended from instr[31]
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] imm_u;

  assign imm_i = {{20{i_instr[31]}}, i_instr[31:20]};
  assign imm_s = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
  assign imm_b = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
  assign imm_j = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
  assign imm_u = {i_instr[31:12], 12'b0};

  // Decoded (combinational) micro-op
  logic [3:0]  cls_d;
  logic        rs1_used_d;
  logic        rs2_used_d;
  logic        writes_rd;
  logic        illegal_d;
  logic [31:0] imm32_d;
  logic        rd_we_d;
  logic [DATA_WIDTH-1:0] imm_d;

  always_comb begin
    cls_d      = CLS_NONE;
    rs1_used_d = 1'b0;
    rs2_used_d = 1'b0;
    writes_rd  = 1'b0;
    illegal_d  = 1'b0;
    imm32_d    = 32'd0;

    unique case (opcode)
      OPC_OP: begin
        cls_d      = CLS_OP;
        rs1_used_d = 1'b1;
        rs2_used_d = 1'b1;
        writes_rd  = 1'b1;
        if (funct7 == F7_ZERO) begin
          illegal_d = 1'b0;
        end else if (funct7 == F7_ALT) begin
          illegal_d = !((funct3 == 3'b000) || (funct3 == 3'b101));
        end else begin
          illegal_d = 1'b1;
        end
      end
      OPC_OP_IMM: begin
        cls_d      = CLS_OP_IMM;
        rs1_used_d = 1'b1;
        writes_rd  = 1'b1;
        imm32_d    = imm_i;
        // Shift-immediates reuse the upper imm bits as a funct7 selector
        if (funct3 == 3'b001) begin
          illegal_d = (funct7 != F7_ZERO);
        end else if (funct3 == 3'b101) begin
          illegal_d = (funct7 != F7_ZERO) && (funct7 != F7_ALT);
        end
      end
      OPC_LOAD: begin
        cls_d      = CLS_LOAD;
        rs1_used_d = 1'b1;
        writes_rd  = 1'b1;
        imm32_d    = imm_i;
        illegal_d  = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      end
      OPC_STORE: begin
        cls_d      = CLS_STORE;
        rs1_used_d = 1'b1;
        rs2_used_d = 1'b1;
        imm32_d    = imm_s;
        illegal_d  = (funct3 > 3'b010);
      end
      OPC_BRANCH: begin
        cls_d      = CLS_BRANCH;
        rs1_used_d = 1'b1;
        rs2_used_d = 1'b1;
        imm32_d    = imm_b;
        illegal_d  = (funct3 == 3'b010) || (funct3 == 3'b011);
      end
      OPC_JAL: begin
        cls_d     = CLS_JAL;
        writes_rd = 1'b1;
        imm32_d   = imm_j;
      end
      OPC_JALR: begin
        cls_d      = CLS_JALR;
        rs1_used_d = 1'b1;
        writes_rd  = 1'b1;
        imm32_d    = imm_i;
        illegal_d  = (funct3 != 3'b000);
      end
      OPC_LUI: begin
        cls_d     = CLS_LUI;
        writes_rd = 1'b1;
        imm32_d   = imm_u;
      end
      OPC_AUIPC: begin
        cls_d     = CLS_AUIPC;
        writes_rd = 1'b1;
        imm32_d   = imm_u;
      end
      OPC_FENCE: begin
        cls_d = CLS_FENCE;
      end
      OPC_SYSTEM: begin
        cls_d = CLS_SYSTEM;
      end
      default: begin
        illegal_d = 1'b1;
      end
    endcase

    // Compressed-space encodings never reach a legal opcode, but guard explicitly
    if (i_instr[1:0] != 2'b11) begin
      illegal_d = 1'b1;
    end

    if (illegal_d) begin
      cls_d      = CLS_NONE;
      rs1_used_d = 1'b0;
      rs2_used_d = 1'b0;
      writes_rd  = 1'b0;
      imm32_d    = 32'd0;
    end
  end

  assign rd_we_d = writes_rd && (rd_addr != 5'd0);
  assign imm_d   = DATA_WIDTH'($signed(imm32_d));

  // Handshake
  logic valid_q;
  logic valid_d;
  logic accept;

  assign o_instr_ready = !valid_q || i_ready;
  assign accept        = i_instr_valid && o_instr_ready && !i_flush;

  always_comb begin
    valid_d = valid_q;
    if (i_flush) begin
      valid_d = 1'b0;
    end else if (accept) begin
      valid_d = 1'b1;
    end else if (i_ready) begin
      valid_d = 1'b0;
    end
  end

  // Payload registers; only loaded on accept, otherwise hold
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [3:0]            cls_q;
  logic [2:0]            funct3_q;
  logic                  funct7b5_q;
  logic [4:0]            rs1_addr_q;
  logic [4:0]            rs2_addr_q;
  logic [4:0]            rd_addr_q;
  logic                  rs1_used_q;
  logic                  rs2_used_q;
  logic                  rd_we_q;
  logic [DATA_WIDTH-1:0] imm_q;
  logic                  illegal_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      valid_q    <= 1'b0;
      pc_q       <= '0;
      cls_q      <= CLS_NONE;
      funct3_q   <= 3'd0;
      funct7b5_q <= 1'b0;
      rs1_addr_q <= 5'd0;
      rs2_addr_q <= 5'd0;
      rd_addr_q  <= 5'd0;
      rs1_used_q <= 1'b0;
      rs2_used_q <= 1'b0;
      rd_we_q    <= 1'b0;
      imm_q      <= '0;
      illegal_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        pc_q       <= i_pc;
        cls_q      <= cls_d;
        funct3_q   <= funct3;
        funct7b5_q <= i_instr[30];
        rs1_addr_q <= rs1_addr;
        rs2_addr_q <= rs2_addr;
        rd_addr_q  <= rd_addr;
        rs1_used_q <= rs1_used_d;
        rs2_used_q <= rs2_used_d;
        rd_we_q    <= rd_we_d;
        imm_q      <= imm_d;
        illegal_q  <= illegal_d;
      end
    end
  end

  assign o_valid    = valid_q;
  assign o_pc       = pc_q;
  assign o_op_class = cls_q;
  assign o_funct3   = funct3_q;
  assign o_funct7b5 = funct7b5_q;
  assign o_rs1_addr = rs1_addr_q;
  assign o_rs2_addr = rs2_addr_q;
  assign o_rd_addr  = rd_addr_q;
  assign o_rs1_used = rs1_used_q;
  assign o_rs2_used = rs2_used_q;
  assign o_rd_we    = rd_we_q;
  assign o_imm      = imm_q;
  assign o_illegal  = illegal_q;

endmodule

// File: tb/tb_bure_stage_id.sv
// Bench for bure_stage_id: directed scenarios then random traffic, checked against an
// arithmetic decode model and a one-entry handshake model.
module tb_bure_stage_id;

  logic        i_clk = 1'b0;
  logic        i_rstn;
  logic        i_flush;
  logic        i_instr_valid;
  logic [31:0] i_instr;
  logic [31:0] i_pc;
  logic        o_instr_ready;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_pc;
  logic [3:0]  o_op_class;
  logic [2:0]  o_funct3;
  logic        o_funct7b5;
  logic [4:0]  o_rs1_addr;
  logic [4:0]  o_rs2_addr;
  logic [4:0]  o_rd_addr;
  logic        o_rs1_used;
  logic        o_rs2_used;
  logic        o_rd_we;
  logic [31:0] o_imm;
  logic        o_illegal;

  bure_stage_id dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_flush(i_flush),
    .i_instr_valid(i_instr_valid), .i_instr(i_instr), .i_pc(i_pc),
    .o_instr_ready(o_instr_ready), .o_valid(o_valid), .i_ready(i_ready),
    .o_pc(o_pc), .o_op_class(o_op_class), .o_funct3(o_funct3), .o_funct7b5(o_funct7b5),
    .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr), .o_rd_addr(o_rd_addr),
    .o_rs1_used(o_rs1_used), .o_rs2_used(o_rs2_used), .o_rd_we(o_rd_we),
    .o_imm(o_imm), .o_illegal(o_illegal)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  cls;
    logic [2:0]  f3;
    logic        f7b5;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        rs1u;
    logic        rs2u;
    logic        rdwe;
    logic [31:0] imm;
    logic        ill;
  } dec_t;

  int   total = 0;
  int   bad   = 0;
  logic m_valid;
  dec_t m_op;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Immediates built by weighted sums of instruction bits, with instr[31] as a negative weight
  function automatic dec_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    dec_t d;
    logic [6:0] f7;
    logic [2:0] f3;
    bit ok;
    bit wr;
    byte fmt;
    int neg12;
    int v;
    d = '0;
    f7 = ins[31:25];
    f3 = ins[14:12];
    d.pc = pc; d.f3 = f3; d.f7b5 = ins[30];
    d.rs1 = ins[19:15]; d.rs2 = ins[24:20]; d.rd = ins[11:7];
    ok = 1; wr = 0; fmt = "N";
    case (ins[6:0])
      7'h33: begin d.cls = 1; fmt = "R"; d.rs1u = 1; d.rs2u = 1; wr = 1;
                   ok = (f7 == 0) || (f7 == 7'h20 && (f3 == 0 || f3 == 5)); end
      7'h13: begin d.cls = 2; fmt = "I"; d.rs1u = 1; wr = 1;
                   if (f3 == 1) ok = (f7 == 0);
                   if (f3 == 5) ok = (f7 == 0) || (f7 == 7'h20); end
      7'h03: begin d.cls = 3; fmt = "I"; d.rs1u = 1; wr = 1; ok = !(f3 == 3 || f3 >= 6); end
      7'h23: begin d.cls = 4; fmt = "S"; d.rs1u = 1; d.rs2u = 1; ok = (f3 <= 2); end
      7'h63: begin d.cls = 5; fmt = "B"; d.rs1u = 1; d.rs2u = 1; ok = !(f3 == 2 || f3 == 3); end
      7'h6F: begin d.cls = 6; fmt = "J"; wr = 1; end
      7'h67: begin d.cls = 7; fmt = "I"; d.rs1u = 1; wr = 1; ok = (f3 == 0); end
      7'h37: begin d.cls = 8; fmt = "U"; wr = 1; end
      7'h17: begin d.cls = 9; fmt = "U"; wr = 1; end
      7'h0F: begin d.cls = 10; end
      7'h73: begin d.cls = 11; end
      default: ok = 0;
    endcase
    if (ins[1:0] != 2'b11) ok = 0;
    neg12 = ins[31] ? -2048 : 0;
    case (fmt)
      "I": v = neg12 + int'(ins[30:20]);
      "S": v = neg12 + int'(ins[30:25]) * 32 + int'(ins[11:7]);
      "B": v = 2 * neg12 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      "J": v = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
               + int'(ins[30:21]) * 2;
      "U": v = int'(ins & 32'hFFFF_F000);
      default: v = 0;
    endcase
    d.imm = v;
    d.rdwe = wr && (d.rd != 0);
    if (!ok) begin
      d.ill = 1; d.cls = 0; d.rs1u = 0; d.rs2u = 0; d.rdwe = 0; d.imm = 0;
    end
    return d;
  endfunction

  task automatic check_outputs();
    chk("valid", 32'(o_valid), 32'(m_valid));
    if (m_valid) begin
      chk("pc", o_pc, m_op.pc);
      chk("class", 32'(o_op_class), 32'(m_op.cls));
      chk("funct3", 32'(o_funct3), 32'(m_op.f3));
      chk("funct7b5", 32'(o_funct7b5), 32'(m_op.f7b5));
      chk("rs1", 32'(o_rs1_addr), 32'(m_op.rs1));
      chk("rs2", 32'(o_rs2_addr), 32'(m_op.rs2));
      chk("rd", 32'(o_rd_addr), 32'(m_op.rd));
      chk("rs1_used", 32'(o_rs1_used), 32'(m_op.rs1u));
      chk("rs2_used", 32'(o_rs2_used), 32'(m_op.rs2u));
      chk("rd_we", 32'(o_rd_we), 32'(m_op.rdwe));
      chk("imm", o_imm, m_op.imm);
      chk("illegal", 32'(o_illegal), 32'(m_op.ill));
    end
  endtask

  // One cycle: drive at posedge+1, check at negedge, advance the model at the edge.
  task automatic step(input logic fl, input logic iv, input logic [31:0] ins,
                      input logic [31:0] pc, input logic rdy);
    logic rdy_exp;
    i_flush = fl; i_instr_valid = iv; i_instr = ins; i_pc = pc; i_ready = rdy;
    @(negedge i_clk);
    rdy_exp = !m_valid || rdy;
    chk("instr_ready", 32'(o_instr_ready), 32'(rdy_exp));
    check_outputs();
    if (fl) m_valid = 0;
    else if (iv && rdy_exp) begin m_valid = 1; m_op = ref_decode(ins, pc); end
    else if (rdy) m_valid = 0;
    @(posedge i_clk);
    #1;
  endtask

  localparam int NOPC = 11;
  logic [6:0] opc_tab [NOPC] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                 7'h67, 7'h37, 7'h17, 7'h0F, 7'h73};

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    if ($urandom_range(0, 99) < 85) begin
      r[6:0] = opc_tab[$urandom_range(0, NOPC - 1)];
      case ($urandom_range(0, 3))
        0: r[31:25] = 7'h00;
        1: r[31:25] = 7'h20;
        default: ;
      endcase
      if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
    end
    return r;
  endfunction

  initial begin
    m_valid = 0;
    m_op = '0;
    i_rstn = 0; i_flush = 0; i_instr_valid = 0; i_instr = 0; i_pc = 0; i_ready = 1;
    @(negedge i_clk);
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_ready", 32'(o_instr_ready), 1);
    chk("rst_pc", o_pc, 0);
    chk("rst_imm", o_imm, 0);
    chk("rst_class", 32'(o_op_class), 0);
    chk("rst_rd_we", 32'(o_rd_we), 0);
    chk("rst_illegal", 32'(o_illegal), 0);
    @(posedge i_clk); #1;
    i_rstn = 1;

    // addi then beq back-to-back, then sw
    step(0, 1, 32'h0050_0093, 32'h100, 1);
    step(0, 1, 32'hFE00_0EE3, 32'h104, 1);
    step(0, 1, 32'h0020_A423, 32'h108, 1);
    // stall three cycles with a new instruction offered, then release
    step(0, 1, 32'h0000_0000, 32'h10C, 0);
    step(0, 1, 32'h0000_0000, 32'h10C, 0);
    step(0, 1, 32'h0000_0000, 32'h10C, 0);
    step(0, 1, 32'h0000_0000, 32'h10C, 1);
    step(0, 1, 32'h0000_0013, 32'h110, 1);
    step(0, 0, 32'h0000_0000, 32'h0, 0);
    // flush with valid input while stalled
    step(1, 1, 32'h0050_0093, 32'h114, 0);
    step(0, 0, 32'h0, 32'h0, 0);
    // async reset while an op is stalled
    step(0, 1, 32'h0050_0093, 32'h200, 1);
    i_instr_valid = 0; i_ready = 0;
    #2 i_rstn = 0;
    #1;
    chk("async_rst_valid", 32'(o_valid), 0);
    chk("async_rst_pc", o_pc, 0);
    m_valid = 0;
    @(posedge i_clk); #1;
    i_rstn = 1;

    for (int n = 0; n < 600; n++) begin
      step($urandom_range(0, 99) < 8, $urandom_range(0, 99) < 75, rand_instr(),
           $urandom & 32'hFFFF_FFFC, $urandom_range(0, 99) < 70);
    end
    step(0, 0, 32'h0, 32'h0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bure_stage_id.md
Name: bure_stage_id

Overview:
- Instruction-decode stage directly downstream of the fetch stage. Consumes the fetched 32-bit RV32I instruction and its PC.
- Produces one registered, decoded micro-op per accepted instruction for the execute stage.
- Owns the IF→ID pipeline boundary: valid/ready backpressure toward fetch, and flush on redirect.

Parameters:
- DATA_WIDTH, 32, datapath / immediate width.
- ADDR_WIDTH, 32, PC width.
- INSTR_WIDTH, 32, instruction width (only 32 supported).

Ports:
- i_clk  in  1  clock.
- i_rstn  in  1  asynchronous active-low reset.
- i_flush  in  1  redirect; kills the held and incoming instruction.
- i_instr_valid  in  1  fetch output valid.
- i_instr  in  INSTR_WIDTH  fetched instruction.
- i_pc  in  ADDR_WIDTH  PC of i_instr.
- o_instr_ready  out  1  decode can accept this cycle.
- o_valid  out  1  decoded op valid toward execute.
- i_ready  in  1  execute accepts the op.
- o_pc  out  ADDR_WIDTH  PC of the decoded op.
- o_op_class  out  4  op class: 0 NONE, 1 OP, 2 OP_IMM, 3 LOAD, 4 STORE, 5 BRANCH, 6 JAL, 7 JALR, 8 LUI, 9 AUIPC, 10 FENCE, 11 SYSTEM.
- o_funct3  out  3  instr[14:12].
- o_funct7b5  out  1  instr[30]. Valid for OP and for shift-immediate ops.
- o_rs1_addr, o_rs2_addr, o_rd_addr  out  5 each  register indices.
- o_rs1_used, o_rs2_used  out  1 each  source operand is read.
- o_rd_we  out  1  writes rd, and rd != 0.
- o_imm  out  DATA_WIDTH  sign-extended immediate.
- o_illegal  out  1  op is an illegal instruction.

Behaviour:
- Reset (async, i_rstn=0): all outputs registered to 0; o_instr_ready=1 combinationally after reset release.
- o_instr_ready = !o_valid | i_ready (single-entry output register). Combinational; no dependency on i_instr_valid.
- Accept condition: i_instr_valid & o_instr_ready & !i_flush.
  - On accept, on the next edge: o_valid=1 and all decoded fields are loaded.
  - Latency is 1 cycle from input to output.
- Output consumed and no accept on the same edge: o_valid←0. Payload fields hold their last values (don't-care).
- Stall (o_valid=1, i_ready=0): all outputs hold stable; o_instr_ready=0.
- i_flush: highest priority. Next edge o_valid=0, regardless of i_ready or i_instr_valid. The incoming instruction is dropped.
- Simultaneous consume + accept: a new op replaces the old one with no bubble. Full throughput is 1 op/cycle.
- Decode on opcode instr[6:0]:
  - 0110011 OP: R-type; rs1/rs2 used; rd_we.
  - 0010011 OP_IMM: I-imm; rs1 used; rd_we.
  - 0000011 LOAD: I-imm; rs1 used; rd_we.
  - 0100011 STORE: S-imm; rs1/rs2 used; no rd_we.
  - 1100011 BRANCH: B-imm, bit0=0; rs1/rs2 used; no rd_we.
  - 1101111 JAL: J-imm; rd_we.
  - 1100111 JALR: I-imm; rs1 used; rd_we.
  - 0110111 LUI and 0010111 AUIPC: U-imm {instr[31:12],12'b0}; rd_we.
  - 0001111 FENCE: treated as NOP; no register use.
  - 1110011 SYSTEM: no rd_we; execute handles it.
- Illegal → o_illegal=1, class NONE, all *_used=0, rd_we=0, imm=0. Illegal cases:
  - any other opcode;
  - instr[1:0] != 11;
  - OP with funct7 not in {0000000, 0100000};
  - OP with funct7=0100000 and funct3 not in {000, 101};
  - OP_IMM shifts (funct3 001/101) with instr[31:25] not in the legal set (0000000; 0100000 for 101 only);
  - LOAD funct3 in {011, 110, 111};
  - STORE funct3 > 010;
  - BRANCH funct3 in {010, 011};
  - JALR funct3 != 000.
- o_rd_we is forced 0 when rd=0.
- All immediates are sign-extended from instr[31] to DATA_WIDTH.
- Reset mid-stall: the pending op is discarded; o_valid=0 immediately (async).

Test Plan:
- addi x1,x0,5 (0x00500093), pc=0x100, i_ready=1 → next cycle o_valid=1, class=2, rd=1, rs1=0, imm=0x00000005, rd_we=1, o_pc=0x100.
- sw x2,8(x1) (0x0020A423) → class=4, rs1=1, rs2=2, imm=0x8, rd_we=0, rs1_used=rs2_used=1.
- beq x0,x0,-4 (0xFE000EE3) → class=5, imm=0xFFFFFFFC; back-to-back with addi at i_ready=1 → o_valid held high 2 cycles, no bubble.
- Stall: i_ready=0 for 3 cycles with op held → outputs stable, o_instr_ready=0; new instr presented meanwhile is not taken. i_ready=1 → that instr appears one cycle later.
- 0x00000000 → o_illegal=1, class=0, rd_we=0. addi x0,x0,0 (0x00000013) → o_illegal=0, rd_we=0.
- i_flush together with a valid input while an op is stalled → next cycle o_valid=0. Async i_rstn=0 mid-cycle → o_valid=0 immediately.
